// File: rtl/flexbex_mem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
//   SRAM_AW  - word-address width of the data SRAM macro (256 words)
//   SRAM_DW  - data width of the macro
//   SRAM_BEW - byte-enable / write-mask width
//   owner_e  - initiator that owns an in-flight access
//   byte2word() - byte address to macro word address
package flexbex_mem_pkg;

    localparam int unsigned SRAM_AW  = 8;
    localparam int unsigned SRAM_DW  = 32;
    localparam int unsigned SRAM_BEW = 4;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_FAB  = 1'b1
    } owner_e;

    // Drops the byte offset; the caller passes just the bits that reach the macro.
    function automatic logic [SRAM_AW-1:0] byte2word(input logic [SRAM_AW+1:0] byte_addr);
        return SRAM_AW'(byte_addr >> 2);
    endfunction

endpackage

// File: rtl/flexbex_rr_arb2.sv
// Two-request round-robin arbiter.
//   clk, resetn - clock and synchronous active-low reset
//   req[1:0]    - requests (bit 0 = core, bit 1 = fabric)
//   gnt[1:0]    - one-hot grant, combinational from req
//   idx         - index of the winning request (valid when any gnt bit is set)
// On a tie the pointer picks the winner; after every grant it moves to the other port.
module flexbex_rr_arb2 #(
    parameter bit FAB_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       idx
);

    logic ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q <= FAB_PRIO;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        idx = req[1];
        if (&req) begin
            idx = ptr_q;
        end
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (|req) begin
            gnt   = idx ? 2'b10 : 2'b01;
            ptr_d = ~idx;
        end
    end

endmodule

// File: rtl/flexbex_dmem_arb.sv
// Core/fabric arbiter and req/gnt/rvalid bridge in front of the data SRAM macro (port 0).
//   clk, resetn        - clock and synchronous active-low reset
//   c_*                - core (Ibex data) initiator: req/gnt/rvalid, byte address
//   f_*                - fabric initiator, same protocol as the core port
//   sram_*             - macro port 0: active-low csb/web, wmask, word address, din/dout
// Optional: FLEXBEX_DMEM_RANGE_ERR_EN makes addresses with upper bits set return an error
// response without touching the macro; otherwise those bits alias and err is tied low.
module flexbex_dmem_arb
    import flexbex_mem_pkg::*;
#(
    parameter int unsigned SRAM_AW  = 8,
    parameter int unsigned IN_AW    = 12,
    parameter bit          FAB_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                c_req_i,
    output logic                c_gnt_o,
    output logic                c_rvalid_o,
    input  logic                c_we_i,
    input  logic [SRAM_BEW-1:0] c_be_i,
    input  logic [IN_AW-1:0]    c_addr_i,
    input  logic [SRAM_DW-1:0]  c_wdata_i,
    output logic [SRAM_DW-1:0]  c_rdata_o,
    output logic                c_err_o,
    input  logic                f_req_i,
    output logic                f_gnt_o,
    output logic                f_rvalid_o,
    input  logic                f_we_i,
    input  logic [SRAM_BEW-1:0] f_be_i,
    input  logic [IN_AW-1:0]    f_addr_i,
    input  logic [SRAM_DW-1:0]  f_wdata_i,
    output logic [SRAM_DW-1:0]  f_rdata_o,
    output logic                f_err_o,
    output logic                sram_csb_o,
    output logic                sram_web_o,
    output logic [SRAM_BEW-1:0] sram_wmask_o,
    output logic [SRAM_AW-1:0]  sram_addr_o,
    output logic [SRAM_DW-1:0]  sram_din_o,
    input  logic [SRAM_DW-1:0]  sram_dout_i
);

    logic [1:0]          req, gnt;
    logic                win;
    logic                any_gnt;
    logic                sel_fab;
    logic                m_we;
    logic [SRAM_BEW-1:0] m_be;
    logic [IN_AW-1:0]    m_addr;
    logic [SRAM_DW-1:0]  m_wdata;
    logic                oor;
    logic                access;

    // Response tag: owner_q doubles as the idle mux select so the macro pins stay quiet.
    owner_e owner_q;
    logic   rvalid_q;
    logic   read_q;
    logic   resp;
    logic   resp_err;
    logic [SRAM_DW-1:0] resp_data;

    // Gating with resetn keeps grants off while reset is asserted.
    assign req = {f_req_i & resetn, c_req_i & resetn};

    flexbex_rr_arb2 #(
        .FAB_PRIO(FAB_PRIO)
    ) u_rr_arb2 (
        .clk   (clk),
        .resetn(resetn),
        .req   (req),
        .gnt   (gnt),
        .idx   (win)
    );

    assign any_gnt = |gnt;
    assign c_gnt_o = gnt[0];
    assign f_gnt_o = gnt[1];

    always_comb begin
        sel_fab = any_gnt ? win : (owner_q == OWN_FAB);
        m_we    = sel_fab ? f_we_i    : c_we_i;
        m_be    = sel_fab ? f_be_i    : c_be_i;
        m_addr  = sel_fab ? f_addr_i  : c_addr_i;
        m_wdata = sel_fab ? f_wdata_i : c_wdata_i;
    end

`ifdef FLEXBEX_DMEM_RANGE_ERR_EN
    logic err_q;

    assign oor = any_gnt & (m_addr[IN_AW-1:SRAM_AW+2] != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (any_gnt) begin
            err_q <= oor;
        end
    end

    assign resp_err = err_q;
`else
    logic unused_addr_hi;

    assign unused_addr_hi = ^m_addr[IN_AW-1:SRAM_AW+2];
    assign oor            = 1'b0;
    assign resp_err       = 1'b0;
`endif

    assign access       = any_gnt & ~oor;
    assign sram_csb_o   = ~access;
    assign sram_web_o   = ~(access & m_we);
    assign sram_wmask_o = m_be;
    assign sram_addr_o  = byte2word(m_addr[SRAM_AW+1:0]);
    assign sram_din_o   = m_wdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rvalid_q <= 1'b0;
            owner_q  <= OWN_CORE;
            read_q   <= 1'b0;
        end else begin
            rvalid_q <= any_gnt;
            if (any_gnt) begin
                owner_q <= owner_e'(win);
                read_q  <= ~m_we;
            end
        end
    end

    always_comb begin
        resp      = rvalid_q & resetn;
        resp_data = (read_q & ~resp_err) ? sram_dout_i : '0;

        c_rvalid_o = resp & (owner_q == OWN_CORE);
        f_rvalid_o = resp & (owner_q == OWN_FAB);
        c_rdata_o  = c_rvalid_o ? resp_data : '0;
        f_rdata_o  = f_rvalid_o ? resp_data : '0;
        c_err_o    = c_rvalid_o & resp_err;
        f_err_o    = f_rvalid_o & resp_err;
    end

endmodule

// File: tb/tb_flexbex_dmem_arb.sv
// Bench for flexbex_dmem_arb: directed vector table, reset/range sequences, random traffic
// checked against a transaction-level model with its own copy of memory.
module tb_flexbex_dmem_arb;

    localparam bit FAB_PRIO = 1'b0;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        c_req = 1'b0, c_we = 1'b0, f_req = 1'b0, f_we = 1'b0;
    logic [3:0]  c_be = '0, f_be = '0;
    logic [11:0] c_addr = '0, f_addr = '0;
    logic [31:0] c_wdata = '0, f_wdata = '0;

    logic        c_gnt_o, c_rvalid_o, c_err_o, f_gnt_o, f_rvalid_o, f_err_o;
    logic [31:0] c_rdata_o, f_rdata_o;
    logic        sram_csb_o, sram_web_o;
    logic [3:0]  sram_wmask_o;
    logic [7:0]  sram_addr_o;
    logic [31:0] sram_din_o;
    bit   [31:0] sram_dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    flexbex_dmem_arb #(
        .SRAM_AW (8),
        .IN_AW   (12),
        .FAB_PRIO(FAB_PRIO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .c_req_i     (c_req),
        .c_gnt_o     (c_gnt_o),
        .c_rvalid_o  (c_rvalid_o),
        .c_we_i      (c_we),
        .c_be_i      (c_be),
        .c_addr_i    (c_addr),
        .c_wdata_i   (c_wdata),
        .c_rdata_o   (c_rdata_o),
        .c_err_o     (c_err_o),
        .f_req_i     (f_req),
        .f_gnt_o     (f_gnt_o),
        .f_rvalid_o  (f_rvalid_o),
        .f_we_i      (f_we),
        .f_be_i      (f_be),
        .f_addr_i    (f_addr),
        .f_wdata_i   (f_wdata),
        .f_rdata_o   (f_rdata_o),
        .f_err_o     (f_err_o),
        .sram_csb_o  (sram_csb_o),
        .sram_web_o  (sram_web_o),
        .sram_wmask_o(sram_wmask_o),
        .sram_addr_o (sram_addr_o),
        .sram_din_o  (sram_din_o),
        .sram_dout_i (sram_dout)
    );

    // Macro behaviour: masked write, or registered read data available the next cycle.
    bit [31:0] sram_mem [256];
    always @(posedge clk) begin
        if (!sram_csb_o) begin
            if (!sram_web_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wmask_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_din_o[8*b +: 8];
                end
            end else begin
                sram_dout <= sram_mem[sram_addr_o];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: who wins this cycle, what the macro should see, what comes back.
    bit [31:0] ref_mem [256];
    bit        last_fab;           // port granted most recently
    bit        m_g, m_fab, m_oor, m_we;
    bit [7:0]  m_word;
    bit [3:0]  m_be;
    bit [31:0] m_wd;
    bit        pv, pfab, perr;     // response owed next cycle
    bit [31:0] pdata;

    task automatic model_check();
        bit cr, fr;
        bit [11:0] a;
        bit exp_cv, exp_fv;
        cr    = resetn && c_req;
        fr    = resetn && f_req;
        m_g   = cr || fr;
        m_fab = (cr && fr) ? !last_fab : fr;
        a     = m_fab ? f_addr  : c_addr;
        m_we  = m_fab ? f_we    : c_we;
        m_be  = m_fab ? f_be    : c_be;
        m_wd  = m_fab ? f_wdata : c_wdata;
        m_word = 8'((a % 1024) / 4);
`ifdef FLEXBEX_DMEM_RANGE_ERR_EN
        m_oor = m_g && (a >= 12'd1024);
`else
        m_oor = 1'b0;
`endif
        chk("c_gnt", c_gnt_o, m_g && !m_fab);
        chk("f_gnt", f_gnt_o, m_g && m_fab);
        chk("csb", sram_csb_o, !(m_g && !m_oor));
        if (m_g && !m_oor) begin
            chk("web", sram_web_o, !m_we);
            chk("addr", sram_addr_o, m_word);
            chk("wmask", sram_wmask_o, m_be);
            chk("din", sram_din_o, m_wd);
        end
        exp_cv = resetn && pv && !pfab;
        exp_fv = resetn && pv && pfab;
        chk("c_rvalid", c_rvalid_o, exp_cv);
        chk("f_rvalid", f_rvalid_o, exp_fv);
        chk("c_rdata", c_rdata_o, exp_cv ? pdata : 32'h0);
        chk("f_rdata", f_rdata_o, exp_fv ? pdata : 32'h0);
        chk("c_err", c_err_o, exp_cv && perr);
        chk("f_err", f_err_o, exp_fv && perr);
    endtask

    task automatic model_update();
        if (!resetn) begin
            pv       = 1'b0;
            last_fab = !FAB_PRIO;  // tie after reset goes to FAB_PRIO's port
        end else begin
            pv    = m_g;
            pfab  = m_fab;
            perr  = m_oor;
            pdata = (m_g && !m_we && !m_oor) ? ref_mem[m_word] : 32'h0;
            if (m_g && m_we && !m_oor) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_be[b]) ref_mem[m_word][8*b +: 8] = m_wd[8*b +: 8];
                end
            end
            if (m_g) last_fab = m_fab;
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic to_pos();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        bit        rst_n;
        bit        cr, cw;
        bit [3:0]  cbe;
        bit [11:0] ca;
        bit [31:0] cd;
        bit        fr, fw;
        bit [3:0]  fbe;
        bit [11:0] fa;
        bit [31:0] fd;
        bit        e_cg, e_fg, e_csb, e_crv, e_frv;
        bit [31:0] e_crd, e_frd;
    } vec_t;

    task automatic rand_port(output logic req, output logic we, output logic [3:0] be,
                             output logic [11:0] addr, output logic [31:0] wd);
        req  = ($urandom_range(0, 3) != 0);
        we   = $urandom_range(0, 1) == 1;
        be   = 4'($urandom_range(0, 15));
        wd   = $urandom;
        addr = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
    endtask

    vec_t tab [19];

    initial begin
        bit exp_err;
        bit [31:0] exp_rd;
        //         rst cr cw cbe   ca      cd            fr fw fbe   fa      fd
        //         cg fg csb crv frv crd            frd
        tab[0]  = '{0, 1, 0, 4'hF, 12'h010, 32'h0,        0, 0, 4'h0, 12'h000, 32'h0,
                    0, 0, 1, 0, 0, 32'h0,        32'h0};
        tab[1]  = tab[0];
        tab[2]  = tab[0];
        tab[3]  = '{1, 1, 1, 4'hF, 12'h010, 32'hDEADBEEF, 0, 0, 4'h0, 12'h000, 32'h0,
                    1, 0, 0, 0, 0, 32'h0,        32'h0};
        tab[4]  = '{1, 1, 0, 4'hF, 12'h010, 32'h0,        0, 0, 4'h0, 12'h000, 32'h0,
                    1, 0, 0, 1, 0, 32'h0,        32'h0};
        tab[5]  = '{1, 1, 1, 4'h1, 12'h010, 32'h000000AA, 0, 0, 4'h0, 12'h000, 32'h0,
                    1, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0};
        tab[6]  = '{1, 1, 0, 4'hF, 12'h010, 32'h0,        0, 0, 4'h0, 12'h000, 32'h0,
                    1, 0, 0, 1, 0, 32'h0,        32'h0};
        tab[7]  = '{1, 0, 0, 4'h0, 12'h000, 32'h0,        1, 1, 4'hF, 12'h014, 32'h12345678,
                    0, 1, 0, 1, 0, 32'hDEADBEAA, 32'h0};
        // Reset drops the fabric write response, and restarts the tie pointer.
        tab[8]  = '{0, 0, 0, 4'h0, 12'h000, 32'h0,        0, 0, 4'h0, 12'h000, 32'h0,
                    0, 0, 1, 0, 0, 32'h0,        32'h0};
        tab[9]  = '{1, 1, 0, 4'hF, 12'h010, 32'h0,        1, 0, 4'hF, 12'h014, 32'h0,
                    1, 0, 0, 0, 0, 32'h0,        32'h0};
        tab[10] = '{1, 1, 0, 4'hF, 12'h010, 32'h0,        1, 0, 4'hF, 12'h014, 32'h0,
                    0, 1, 0, 1, 0, 32'hDEADBEAA, 32'h0};
        tab[11] = '{1, 1, 0, 4'hF, 12'h010, 32'h0,        1, 0, 4'hF, 12'h014, 32'h0,
                    1, 0, 0, 0, 1, 32'h0,        32'h12345678};
        tab[12] = tab[10];
        tab[13] = tab[11];
        tab[14] = tab[10];
        tab[15] = '{1, 0, 0, 4'h0, 12'h000, 32'h0,        0, 0, 4'h0, 12'h000, 32'h0,
                    0, 0, 1, 0, 1, 32'h0,        32'h12345678};
        // be = 0 write with misaligned address: accessed, nothing changes.
        tab[16] = '{1, 1, 1, 4'h0, 12'h013, 32'hFFFFFFFF, 0, 0, 4'h0, 12'h000, 32'h0,
                    1, 0, 0, 0, 0, 32'h0,        32'h0};
        tab[17] = '{1, 1, 0, 4'hF, 12'h010, 32'h0,        0, 0, 4'h0, 12'h000, 32'h0,
                    1, 0, 0, 1, 0, 32'h0,        32'h0};
        tab[18] = '{1, 0, 0, 4'h0, 12'h000, 32'h0,        0, 0, 4'h0, 12'h000, 32'h0,
                    0, 0, 1, 1, 0, 32'hDEADBEAA, 32'h0};

        #1;
        for (int i = 0; i < 19; i++) begin
            resetn = tab[i].rst_n;
            c_req = tab[i].cr; c_we = tab[i].cw; c_be = tab[i].cbe;
            c_addr = tab[i].ca; c_wdata = tab[i].cd;
            f_req = tab[i].fr; f_we = tab[i].fw; f_be = tab[i].fbe;
            f_addr = tab[i].fa; f_wdata = tab[i].fd;
            to_neg();
            chk($sformatf("tab%0d_cgnt", i), c_gnt_o, tab[i].e_cg);
            chk($sformatf("tab%0d_fgnt", i), f_gnt_o, tab[i].e_fg);
            chk($sformatf("tab%0d_csb", i), sram_csb_o, tab[i].e_csb);
            chk($sformatf("tab%0d_crv", i), c_rvalid_o, tab[i].e_crv);
            chk($sformatf("tab%0d_frv", i), f_rvalid_o, tab[i].e_frv);
            chk($sformatf("tab%0d_crd", i), c_rdata_o, tab[i].e_crd);
            chk($sformatf("tab%0d_frd", i), f_rdata_o, tab[i].e_frd);
            if (i == 3) chk("tab3_sram_addr", sram_addr_o, 8'h04);
            to_pos();
        end

        // Core read granted, then reset on the following edge: its response never appears.
        resetn = 1; c_req = 1; c_we = 0; c_be = 4'hF; c_addr = 12'h010; f_req = 0;
        to_neg(); chk("rmid_gnt", c_gnt_o, 1'b1); to_pos();
        resetn = 0; c_req = 0;
        to_neg(); chk("rmid_rv_a", c_rvalid_o, 1'b0); to_pos();
        resetn = 1;
        to_neg(); chk("rmid_rv_b", c_rvalid_o, 1'b0); to_pos();
        to_neg(); chk("rmid_rv_c", c_rvalid_o, 1'b0); to_pos();

        // Out-of-range fabric read after seeding word 0.
        c_req = 1; c_we = 1; c_be = 4'hF; c_addr = 12'h000; c_wdata = 32'hCAFEF00D;
        to_neg(); to_pos();
        c_req = 0; f_req = 1; f_we = 0; f_be = 4'hF; f_addr = 12'h800;
`ifdef FLEXBEX_DMEM_RANGE_ERR_EN
        exp_err = 1'b1; exp_rd = 32'h0;
`else
        exp_err = 1'b0; exp_rd = 32'hCAFEF00D;
`endif
        to_neg();
        chk("range_fgnt", f_gnt_o, 1'b1);
        chk("range_csb", sram_csb_o, exp_err);
        to_pos();
        f_req = 0;
        to_neg();
        chk("range_frv", f_rvalid_o, 1'b1);
        chk("range_ferr", f_err_o, exp_err);
        chk("range_frd", f_rdata_o, exp_rd);
        to_pos();

        // Random traffic; a pending request holds its fields until granted or withdrawn.
        for (int n = 0; n < 3000; n++) begin
            if (c_req && !(m_g && !m_fab)) begin
                if ($urandom_range(0, 9) == 0) c_req = 0;
            end else begin
                rand_port(c_req, c_we, c_be, c_addr, c_wdata);
            end
            if (f_req && !(m_g && m_fab)) begin
                if ($urandom_range(0, 9) == 0) f_req = 0;
            end else begin
                rand_port(f_req, f_we, f_be, f_addr, f_wdata);
            end
            resetn = ($urandom_range(0, 99) != 0);
            to_neg();
            to_pos();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
